// File: rtl/tick_digit_pkg.sv
// Purpose: shared widths and seven-segment lookup for the tick/digit driver.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package tick_digit_pkg;

   localparam int DIGIT_W = 4;
   localparam int SEG_W   = 7;

   // Blank pattern used for digit codes that have no glyph.
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   // Active-high segment patterns, bit 0 = a .. bit 6 = g.
   localparam logic [SEG_W-1:0] SEG_LUT [10] = '{
      7'h3F,   // 0
      7'h06,   // 1
      7'h5B,   // 2
      7'h4F,   // 3
      7'h66,   // 4
      7'h6D,   // 5
      7'h7D,   // 6
      7'h07,   // 7
      7'h7F,   // 8
      7'h6F    // 9
   };

   // Codes 10..15 fall outside the table and map to blank.
   function automatic logic [SEG_W-1:0] seg_lookup(input logic [DIGIT_W-1:0] d);
      if (d <= 4'd9) begin
         return SEG_LUT[d];
      end
      return SEG_BLANK;
   endfunction

endpackage

// File: rtl/tick_digit_driver_seg7_decode.sv
// Purpose: combinational 4-bit digit to 7-segment pattern decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   digit  in  DIGIT_W  binary digit code
//   seg    out SEG_W    segment pattern, seg[0]=a .. seg[6]=g, 1 = lit
module seg7_decode
   import tick_digit_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [SEG_W-1:0]   seg
);

   always_comb begin
      seg = SEG_BLANK;
      seg = seg_lookup(digit);
   end

endmodule

// File: rtl/tick_digit_driver.sv
// Purpose: programmable tick prescaler feeding a decimal digit counter and
//          a registered seven-segment driver.
// Latency: tick/digit/seg/wrap all update on the edge that ends the period.
// Backpressure: none; enable low freezes the prescaler and stretches the period.
//
// Ports:
//   clk         in   1      clock
//   reset       in   1      synchronous, active-high; overrides everything
//   enable      in   1      prescaler advances only when high
//   compare_in  in   CNT_W  period in clk cycles; 0 selects MAX_COUNT
//   tick        out  1      one-cycle pulse per elapsed period
//   wrap        out  1      one-cycle pulse on the tick where digit rolls to 0
//   digit       out  4      current digit 0..DIGIT_MAX
//   seg         out  7      registered segment lines, 1 = lit
//   dp          out  1      decimal point, 1 = lit
//
// Build option: define DP_BLINK_EN to make dp toggle on every tick; otherwise
// dp is tied low.
module tick_digit_driver
   import tick_digit_pkg::*;
#(
   parameter int               CNT_W     = 24,
   parameter logic [CNT_W-1:0] MAX_COUNT = 24'd10_000_000,
   parameter int               DIGIT_MAX = 9            // legal range 1..9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [CNT_W-1:0]    compare_in,
   output logic                tick,
   output logic                wrap,
   output logic [DIGIT_W-1:0]  digit,
   output logic [SEG_W-1:0]    seg,
   output logic                dp
);

   localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
   localparam logic [DIGIT_W-1:0] DIGIT_TOP = DIGIT_W'(DIGIT_MAX);

   logic [CNT_W-1:0]   pcnt_q;
   logic [CNT_W-1:0]   cmp_q;
   logic [CNT_W-1:0]   eff_cmp;
   logic               restart;
   logic               tick_q;
   logic               wrap_q;
   logic [DIGIT_W-1:0] digit_q;
   logic [DIGIT_W-1:0] digit_d;
   logic [SEG_W-1:0]   seg_q;
   logic [SEG_W-1:0]   seg_d;

   // A zero compare means "use the built-in period"; cmp_q is therefore
   // never zero and cmp_q - 1 cannot underflow.
   assign eff_cmp = (compare_in == '0) ? MAX_COUNT : compare_in;

   // Terminal count of the current period. With cmp_q == 1 this holds on
   // every enabled cycle and pcnt_q never leaves 0.
   assign restart = enable && (pcnt_q == (cmp_q - CNT_ONE));

   // Next-state digit. Reset is folded in here so the segment decoder sees
   // the same value the digit register is about to load, keeping seg and
   // digit in lockstep without a second pipeline stage.
   always_comb begin
      digit_d = digit_q;
      if (reset) begin
         digit_d = '0;
      end else if (restart) begin
         digit_d = (digit_q == DIGIT_TOP) ? '0 : digit_q + 1'b1;
      end
   end

   seg7_decode u_seg7_decode (
      .digit (digit_d),
      .seg   (seg_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt_q  <= '0;
         cmp_q   <= eff_cmp;
         tick_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         tick_q <= restart;
         wrap_q <= restart && (digit_q == DIGIT_TOP);
         if (restart) begin
            pcnt_q <= '0;
            // The new period is only sampled here, so compare_in changes
            // mid-period do not disturb the period in flight.
            cmp_q  <= eff_cmp;
         end else if (enable) begin
            pcnt_q <= pcnt_q + CNT_ONE;
         end
      end
      digit_q <= digit_d;
      seg_q   <= seg_d;
   end

`ifdef DP_BLINK_EN
   logic dp_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         dp_q <= 1'b0;
      end else if (restart) begin
         dp_q <= ~dp_q;
      end
   end

   assign dp = dp_q;
`else
   assign dp = 1'b0;
`endif

   assign tick  = tick_q;
   assign wrap  = wrap_q;
   assign digit = digit_q;
   assign seg   = seg_q;

endmodule

// File: tb/tb_tick_digit_driver.sv
// Purpose: directed self-checking bench for tick_digit_driver.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: n/a.
//
// The DUT is built with MAX_COUNT=20 so the compare_in==0 path is reachable
// in a short run. Cycle numbers count rising edges after reset release.
module tb_tick_digit_driver;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [23:0] compare_in;
   logic        tick;
   logic        wrap;
   logic [3:0]  digit;
   logic [6:0]  seg;
   logic        dp;

   int checks;
   int failures;

   tick_digit_driver #(
      .CNT_W     (24),
      .MAX_COUNT (24'd20),
      .DIGIT_MAX (9)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .compare_in (compare_in),
      .tick       (tick),
      .wrap       (wrap),
      .digit      (digit),
      .seg        (seg),
      .dp         (dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-entered glyph table.
   function automatic logic [6:0] seg_of(input int d);
      case (d)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Hold reset for two edges with the given compare value, release it just
   // after an edge; the next edge is cycle 1.
   task automatic do_reset(input logic [23:0] cmp);
      reset      = 1'b1;
      enable     = 1'b1;
      compare_in = cmp;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset;
      do_reset(24'd5);
      checks += 5;
      if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick); end
      if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
      if (digit !== 4'd0) begin failures++; $display("FAIL reset_digit got=%0d exp=0", digit); end
      if (seg !== 7'h3F) begin failures++; $display("FAIL reset_seg got=%h exp=3f", seg); end
      if (dp !== 1'b0) begin failures++; $display("FAIL reset_dp got=%b exp=0", dp); end
   endtask

   // Period 5: ticks at 5,10,..; digit 9 at 45; wrap with digit 0 at 50.
   task automatic test_period5;
      logic       et, ew;
      logic [3:0] ed;
      do_reset(24'd5);
      for (int c = 1; c <= 52; c++) begin
         @(posedge clk); #1;
         et = (c % 5 == 0);
         ew = (c == 50);
         ed = 4'((c / 5) % 10);
         checks += 4;
         if (tick !== et) begin failures++; $display("FAIL p5_tick c=%0d got=%b exp=%b", c, tick, et); end
         if (wrap !== ew) begin failures++; $display("FAIL p5_wrap c=%0d got=%b exp=%b", c, wrap, ew); end
         if (digit !== ed) begin failures++; $display("FAIL p5_digit c=%0d got=%0d exp=%0d", c, digit, ed); end
         if (seg !== seg_of(int'(ed))) begin failures++; $display("FAIL p5_seg c=%0d got=%h exp=%h", c, seg, seg_of(int'(ed))); end
      end
   endtask

   // compare_in=0 selects MAX_COUNT=20.
   task automatic test_max_count;
      logic       et;
      logic [3:0] ed;
      do_reset(24'd0);
      for (int c = 1; c <= 21; c++) begin
         @(posedge clk); #1;
         et = (c == 20);
         ed = (c >= 20) ? 4'd1 : 4'd0;
         checks += 3;
         if (tick !== et) begin failures++; $display("FAIL max_tick c=%0d got=%b exp=%b", c, tick, et); end
         if (digit !== ed) begin failures++; $display("FAIL max_digit c=%0d got=%0d exp=%0d", c, digit, ed); end
         if (seg !== seg_of(int'(ed))) begin failures++; $display("FAIL max_seg c=%0d got=%h exp=%h", c, seg, seg_of(int'(ed))); end
      end
   endtask

   // Period 8, compare switched to 3 after cycle 4: ticks at 8, 11, 14.
   task automatic test_compare_switch;
      logic       et;
      logic [3:0] ed;
      do_reset(24'd8);
      for (int c = 1; c <= 15; c++) begin
         @(posedge clk); #1;
         et = (c == 8) || (c == 11) || (c == 14);
         ed = (c >= 14) ? 4'd3 : (c >= 11) ? 4'd2 : (c >= 8) ? 4'd1 : 4'd0;
         checks += 2;
         if (tick !== et) begin failures++; $display("FAIL sw_tick c=%0d got=%b exp=%b", c, tick, et); end
         if (digit !== ed) begin failures++; $display("FAIL sw_digit c=%0d got=%0d exp=%0d", c, digit, ed); end
         if (c == 4) compare_in = 24'd3;
      end
   endtask

   // Period 4 with enable low for 5 edges: first tick moves from 4 to 9.
   task automatic test_enable_gap;
      logic       et;
      logic [3:0] ed;
      do_reset(24'd4);
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         et = (c == 9);
         ed = (c >= 9) ? 4'd1 : 4'd0;
         checks += 2;
         if (tick !== et) begin failures++; $display("FAIL gap_tick c=%0d got=%b exp=%b", c, tick, et); end
         if (digit !== ed) begin failures++; $display("FAIL gap_digit c=%0d got=%0d exp=%0d", c, digit, ed); end
         if (c == 2) enable = 1'b0;
         if (c == 7) enable = 1'b1;
      end
   endtask

   // Period 1: tick every cycle, wrap at 10, then a mid-run reset.
   task automatic test_back_to_back;
      logic       ew;
      logic [3:0] ed;
      do_reset(24'd1);
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         ew = (c == 10);
         ed = 4'(c % 10);
         checks += 4;
         if (tick !== 1'b1) begin failures++; $display("FAIL b2b_tick c=%0d got=%b exp=1", c, tick); end
         if (wrap !== ew) begin failures++; $display("FAIL b2b_wrap c=%0d got=%b exp=%b", c, wrap, ew); end
         if (digit !== ed) begin failures++; $display("FAIL b2b_digit c=%0d got=%0d exp=%0d", c, digit, ed); end
         if (seg !== seg_of(int'(ed))) begin failures++; $display("FAIL b2b_seg c=%0d got=%h exp=%h", c, seg, seg_of(int'(ed))); end
      end
      reset = 1'b1;
      @(posedge clk); #1;
      checks += 4;
      if (tick !== 1'b0) begin failures++; $display("FAIL midrst_tick got=%b exp=0", tick); end
      if (wrap !== 1'b0) begin failures++; $display("FAIL midrst_wrap got=%b exp=0", wrap); end
      if (digit !== 4'd0) begin failures++; $display("FAIL midrst_digit got=%0d exp=0", digit); end
      if (seg !== 7'h3F) begin failures++; $display("FAIL midrst_seg got=%h exp=3f", seg); end
      reset = 1'b0;
   endtask

   // Period 2: dp toggles on each tick when blinking is built in.
   task automatic test_dp;
      logic ep;
      do_reset(24'd2);
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
`ifdef DP_BLINK_EN
         ep = ((c / 2) % 2) == 1;
`else
         ep = 1'b0;
`endif
         checks += 1;
         if (dp !== ep) begin failures++; $display("FAIL dp c=%0d got=%b exp=%b", c, dp, ep); end
      end
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      reset      = 1'b1;
      enable     = 1'b0;
      compare_in = 24'd0;
      test_reset();
      test_period5();
      test_max_count();
      test_compare_switch();
      test_enable_gap();
      test_back_to_back();
      test_dp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
